// File: rtl/rv_mdu_pkg.sv
// rv_mdu_pkg: operation codes, FSM state type and op-decode helpers shared by
// the iterative multiply/divide unit.
package rv_mdu_pkg;

    localparam int MDU_OP_W = 3;

    localparam logic [MDU_OP_W-1:0] MDU_MUL    = 3'd0;
    localparam logic [MDU_OP_W-1:0] MDU_MULH   = 3'd1;
    localparam logic [MDU_OP_W-1:0] MDU_MULHSU = 3'd2;
    localparam logic [MDU_OP_W-1:0] MDU_MULHU  = 3'd3;
    localparam logic [MDU_OP_W-1:0] MDU_DIV    = 3'd4;
    localparam logic [MDU_OP_W-1:0] MDU_DIVU   = 3'd5;
    localparam logic [MDU_OP_W-1:0] MDU_REM    = 3'd6;
    localparam logic [MDU_OP_W-1:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        MDU_IDLE,
        MDU_CALC,
        MDU_FIX,
        MDU_DONE
    } mdu_state_e;

    // True for DIV/DIVU/REM/REMU.
    function automatic logic is_div(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU) ||
               (op == MDU_REM) || (op == MDU_REMU);
    endfunction

    // rs1 is interpreted as two's complement.
    function automatic logic a_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULH) || (op == MDU_MULHSU) ||
               (op == MDU_DIV)  || (op == MDU_REM);
    endfunction

    // rs2 is interpreted as two's complement.
    function automatic logic b_signed(input logic [MDU_OP_W-1:0] op);
        return (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    endfunction

endpackage

// File: rtl/rv_mdu_divstep.sv
// rv_mdu_divstep: one combinational restoring-division step. Shifts the next
// dividend bit into the partial remainder and subtracts the divisor if it fits.
module rv_mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_rem,
    input  logic            i_msb,
    input  logic [XLEN-1:0] i_dsr,
    output logic [XLEN-1:0] o_rem,
    output logic            o_q
);

    logic [XLEN:0] w_shift;
    logic [XLEN:0] w_diff;

    // Partial remainder is always below the divisor, so the shifted value
    // fits in XLEN+1 bits and a borrow shows up in the top bit of the difference.
    always_comb begin
        w_shift = {i_rem, i_msb};
        w_diff  = w_shift - {1'b0, i_dsr};
        o_q     = ~w_diff[XLEN];
        o_rem   = o_q ? w_diff[XLEN-1:0] : w_shift[XLEN-1:0];
    end

endmodule

// File: rtl/rv_mdu_iter.sv
// rv_mdu_iter: iterative RV32M/RV64M multiply/divide unit. Works on operand
// magnitudes one bit per cycle (the first bit is taken on the accepting edge),
// then a FIX cycle applies the sign and selects the result half.
// Optional build macro RV_MDU_FAST_MUL_EN: multiplies skip the iterative CALC
// phase and FIX registers a single-cycle full product instead.
module rv_mdu_iter
    import rv_mdu_pkg::*;
#(
    parameter  int XLEN  = 32,
    localparam int CNT_W = $clog2(XLEN)
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                req_valid_i,
    output logic                req_ready_o,
    input  logic [MDU_OP_W-1:0] op_i,
    input  logic [XLEN-1:0]     a_i,
    input  logic [XLEN-1:0]     b_i,
    input  logic                kill_i,
    output logic                res_valid_o,
    input  logic                res_ready_i,
    output logic [XLEN-1:0]     res_o,
    output logic                busy_o
);

    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e            r_state;
    mdu_state_e            w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_res_valid;
    logic [XLEN-1:0]       r_res;
    logic [MDU_OP_W-1:0]   r_op;
    logic                  r_neg_q;
    logic                  r_neg_r;
    logic [2*XLEN-1:0]     r_acc;
    logic [2*XLEN-1:0]     r_mcand;
    logic [XLEN-1:0]       r_mplier;
    logic [XLEN-1:0]       r_rem;
    logic [XLEN-1:0]       r_dvd;
    logic [XLEN-1:0]       r_dsr;

    logic                  w_accept;
    logic                  w_sa;
    logic                  w_sb;
    logic [XLEN-1:0]       w_ma;
    logic [XLEN-1:0]       w_mb;
    logic                  w_div_zero;
    logic                  w_div_ovf;
    logic                  w_special;
    logic                  w_fast;
    logic [XLEN-1:0]       w_special_res;
    logic [XLEN-1:0]       w_ds_rem_in;
    logic                  w_ds_msb;
    logic [XLEN-1:0]       w_ds_dsr;
    logic [XLEN-1:0]       w_ds_rem;
    logic                  w_ds_q;
    logic [2*XLEN-1:0]     w_prod_mag;
    logic [2*XLEN-1:0]     w_prod;
    logic [XLEN-1:0]       w_quo;
    logic [XLEN-1:0]       w_remv;
    logic [XLEN-1:0]       w_fix_res;

    // Request decode: acceptance, operand signs/magnitudes and divide special cases.
    always_comb begin
        w_accept   = req_valid_i && (r_state == MDU_IDLE) && !kill_i;
        w_sa       = a_signed(op_i) && a_i[XLEN-1];
        w_sb       = b_signed(op_i) && b_i[XLEN-1];
        w_ma       = w_sa ? -a_i : a_i;
        w_mb       = w_sb ? -b_i : b_i;
        w_div_zero = is_div(op_i) && (b_i == '0);
        w_div_ovf  = ((op_i == MDU_DIV) || (op_i == MDU_REM)) &&
                     (a_i == SMIN) && (b_i == '1);
        w_special  = w_div_zero || w_div_ovf;
        w_special_res = '0;
        if ((op_i == MDU_DIV) || (op_i == MDU_DIVU)) begin
            w_special_res = w_div_zero ? '1 : a_i;
        end else begin
            w_special_res = w_div_zero ? a_i : '0;
        end
`ifdef RV_MDU_FAST_MUL_EN
        w_fast = !is_div(op_i);
`else
        w_fast = 1'b0;
`endif
    end

    // The divide step is shared: the accepting edge feeds it fresh magnitudes,
    // CALC feeds it the running remainder/dividend.
    always_comb begin
        if (r_state == MDU_IDLE) begin
            w_ds_rem_in = '0;
            w_ds_msb    = w_ma[XLEN-1];
            w_ds_dsr    = w_mb;
        end else begin
            w_ds_rem_in = r_rem;
            w_ds_msb    = r_dvd[XLEN-1];
            w_ds_dsr    = r_dsr;
        end
    end

    rv_mdu_divstep #(
        .XLEN (XLEN)
    ) u_divstep (
        .i_rem (w_ds_rem_in),
        .i_msb (w_ds_msb),
        .i_dsr (w_ds_dsr),
        .o_rem (w_ds_rem),
        .o_q   (w_ds_q)
    );

    // Sign correction and result selection for the FIX cycle.
    always_comb begin
`ifdef RV_MDU_FAST_MUL_EN
        w_prod_mag = {{XLEN{1'b0}}, r_mcand[XLEN-1:0]} * {{XLEN{1'b0}}, r_mplier};
`else
        w_prod_mag = r_acc;
`endif
        w_prod = r_neg_q ? -w_prod_mag : w_prod_mag;
        w_quo  = r_neg_q ? -r_dvd : r_dvd;
        w_remv = r_neg_r ? -r_rem : r_rem;
        case (r_op)
            MDU_MUL:                          w_fix_res = w_prod[XLEN-1:0];
            MDU_MULH, MDU_MULHSU, MDU_MULHU:  w_fix_res = w_prod[2*XLEN-1:XLEN];
            MDU_DIV, MDU_DIVU:                w_fix_res = w_quo;
            default:                          w_fix_res = w_remv;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= MDU_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state logic; kill overrides every busy state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            MDU_IDLE: begin
                if (w_accept) begin
                    if (w_special)   w_next = MDU_DONE;
                    else if (w_fast) w_next = MDU_FIX;
                    else             w_next = MDU_CALC;
                end
            end
            MDU_CALC: if (r_cnt == CNT_W'(XLEN-1)) w_next = MDU_FIX;
            MDU_FIX:  w_next = MDU_DONE;
            MDU_DONE: if (res_ready_i) w_next = MDU_IDLE;
            default:  w_next = MDU_IDLE;
        endcase
        if (kill_i && (r_state != MDU_IDLE)) w_next = MDU_IDLE;
    end

    // FSM outputs decoded from the current state.
    always_comb begin
        req_ready_o = (r_state == MDU_IDLE);
        busy_o      = (r_state != MDU_IDLE);
        res_valid_o = r_res_valid;
        res_o       = r_res;
    end

    // Control registers: iteration counter, result valid and result value.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
            r_res       <= '0;
        end else begin
            r_res_valid <= (w_next == MDU_DONE);
            if (w_accept) begin
                r_cnt <= CNT_W'(1);
            end else if (r_state == MDU_CALC) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_accept && w_special) begin
                r_res <= w_special_res;
            end else if ((r_state == MDU_FIX) && !kill_i) begin
                r_res <= w_fix_res;
            end
        end
    end

    // Datapath: capture at accept (first bit processed here), one bit per CALC cycle.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_op    <= op_i;
            r_neg_q <= w_sa ^ w_sb;
            r_neg_r <= w_sa;
`ifdef RV_MDU_FAST_MUL_EN
            r_acc    <= '0;
            r_mcand  <= {{XLEN{1'b0}}, w_ma};
            r_mplier <= w_mb;
`else
            r_acc    <= w_mb[0] ? {{XLEN{1'b0}}, w_ma} : '0;
            r_mcand  <= {{(XLEN-1){1'b0}}, w_ma, 1'b0};
            r_mplier <= {1'b0, w_mb[XLEN-1:1]};
`endif
            r_rem   <= w_ds_rem;
            r_dvd   <= {w_ma[XLEN-2:0], w_ds_q};
            r_dsr   <= w_mb;
        end else if (r_state == MDU_CALC) begin
            if (r_mplier[0]) r_acc <= r_acc + r_mcand;
            r_mcand  <= {r_mcand[2*XLEN-2:0], 1'b0};
            r_mplier <= {1'b0, r_mplier[XLEN-1:1]};
            r_rem    <= w_ds_rem;
            r_dvd    <= {r_dvd[XLEN-2:0], w_ds_q};
        end
    end

endmodule

// File: tb/tb_rv_mdu_iter.sv
// tb_rv_mdu_iter: directed bench for rv_mdu_iter (XLEN=32) with an expected-result queue.
module tb_rv_mdu_iter;
    import rv_mdu_pkg::*;

    localparam int XLEN = 32;
`ifdef RV_MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = XLEN + 1;
`endif
    localparam int DIV_LAT = XLEN + 1;
    localparam int SPC_LAT = 1;

    logic                clk = 1'b0;
    logic                rst_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [MDU_OP_W-1:0] op_i;
    logic [XLEN-1:0]     a_i;
    logic [XLEN-1:0]     b_i;
    logic                kill_i;
    logic                res_valid_o;
    logic                res_ready_i;
    logic [XLEN-1:0]     res_o;
    logic                busy_o;

    int checks   = 0;
    int failures = 0;
    logic [XLEN-1:0] exp_q[$];

    always #5 clk = ~clk;

    rv_mdu_iter #(.XLEN(XLEN)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .op_i        (op_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .kill_i      (kill_i),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .res_o       (res_o),
        .busy_o      (busy_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its result, compare latency and value, then release it.
    task automatic run_op(input string tag, input logic [MDU_OP_W-1:0] op,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input logic [XLEN-1:0] exp, input int lat);
        int n;
        logic [XLEN-1:0] want;
        exp_q.push_back(exp);
        @(negedge clk);
        chk({tag, "_ready"}, {63'd0, req_ready_o}, 64'd1);
        op_i = op; a_i = a; b_i = b; req_valid_i = 1'b1; res_ready_i = 1'b0;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        op_i = MDU_MULHU; a_i = $urandom; b_i = $urandom;
        n = 1;
        while (!res_valid_o && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'(lat));
        want = exp_q.pop_front();
        chk({tag, "_res"}, {32'd0, res_o}, {32'd0, want});
        res_ready_i = 1'b1;
        @(posedge clk);
        #1;
        res_ready_i = 1'b0;
        chk({tag, "_idle"}, {62'd0, res_valid_o, req_ready_o}, 64'd1);
    endtask

    initial begin
        int seen;
        logic [XLEN-1:0] held;
        logic [XLEN-1:0] want;

        rst_i = 1'b1; req_valid_i = 1'b0; kill_i = 1'b0; res_ready_i = 1'b0;
        op_i = MDU_MUL; a_i = '0; b_i = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_res",       {32'd0, res_o}, 64'd0);
        chk("rst_res_valid", {63'd0, res_valid_o}, 64'd0);
        chk("rst_req_ready", {63'd0, req_ready_o}, 64'd1);
        chk("rst_busy",      {63'd0, busy_o}, 64'd0);
        rst_i = 1'b0;

        run_op("mul",    MDU_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT);
        run_op("mulh",   MDU_MULH,   32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT);
        run_op("mulhu",  MDU_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT);
        run_op("mulhsu", MDU_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT);
        run_op("div",    MDU_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, DIV_LAT);
        run_op("rem",    MDU_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, DIV_LAT);
        run_op("divu",   MDU_DIVU,   32'd100,      32'd7,        32'd14,       DIV_LAT);
        run_op("remu",   MDU_REMU,   32'd100,      32'd7,        32'd2,        DIV_LAT);
        run_op("div0",   MDU_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, SPC_LAT);
        run_op("remu0",  MDU_REMU,   32'd5,        32'd0,        32'd5,        SPC_LAT);
        run_op("divovf", MDU_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, SPC_LAT);
        run_op("removf", MDU_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        SPC_LAT);

        // Backpressure: result held in DONE, a competing request is not taken.
        exp_q.push_back(32'd2);
        @(negedge clk);
        op_i = MDU_REM; a_i = 32'd17; b_i = 32'd5; req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        op_i = MDU_MUL; a_i = 32'd9; b_i = 32'd9;
        seen = 0;
        while (!res_valid_o && seen < 200) begin
            @(posedge clk);
            #1;
            seen++;
        end
        want = exp_q.pop_front();
        chk("bp_res", {32'd0, res_o}, {32'd0, want});
        held = res_o;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp_hold_res", {32'd0, res_o}, {32'd0, held});
            chk("bp_hold_flags", {62'd0, res_valid_o, req_ready_o}, 64'd2);
        end
        res_ready_i = 1'b1; req_valid_i = 1'b0;
        @(posedge clk);
        #1;
        res_ready_i = 1'b0;
        chk("bp_release", {61'd0, res_valid_o, req_ready_o, busy_o}, 64'd2);

        // Kill ten edges into a DIVU: back to IDLE and the result is never presented.
        @(negedge clk);
        op_i = MDU_DIVU; a_i = 32'd100; b_i = 32'd7; req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        seen = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (res_valid_o) seen++;
        end
        chk("kill_busy", {62'd0, busy_o, req_ready_o}, 64'd2);
        kill_i = 1'b1;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        chk("kill_idle", {61'd0, res_valid_o, req_ready_o, busy_o}, 64'd2);
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid_o) seen++;
        end
        chk("kill_no_result", 64'(seen), 64'd0);
        run_op("post_kill_mul", MDU_MUL, 32'd3, 32'd4, 32'd12, MUL_LAT);

        // Reset mid-CALC: outputs return to reset values, in-flight result dropped.
        @(negedge clk);
        op_i = MDU_DIV; a_i = 32'd1000; b_i = 32'd3; req_valid_i = 1'b1;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk("midrst_res", {32'd0, res_o}, 64'd0);
        chk("midrst_flags", {61'd0, res_valid_o, req_ready_o, busy_o}, 64'd2);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (res_valid_o) seen++;
        end
        chk("midrst_no_result", 64'(seen), 64'd0);
        run_op("post_rst_divu", MDU_DIVU, 32'd1000, 32'd3, 32'd333, DIV_LAT);

        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv_mdu_iter.md
Name: rv_mdu_iter

Overview:
Parametrised iterative multiply/divide unit executing the RV32M/RV64M operations encoded by the rv_mdu_pkg op codes.
- Generalised in XLEN.
- valid/ready request and result handshakes, kill (flush) input, busy indication.
- Sits beside the ALU in the execute stage; the pipeline stalls on req_ready_o/res_valid_o.
- Shift-add multiply and restoring divide, one bit per cycle on operand magnitudes, with a final sign-fix cycle.

Parameters:
XLEN, 32, operand/result width (32 or 64)
CNT_W, $clog2(XLEN), iteration counter width (derived, not overridden)

Ports:
clk_i  in  1  clock, all state updates on rising edge
rst_i  in  1  synchronous reset, active-high
req_valid_i  in  1  request present
req_ready_o  out  1  unit can accept a request
op_i  in  MDU_OP_W  operation (MDU_MUL..MDU_REMU)
a_i  in  XLEN  rs1 operand
b_i  in  XLEN  rs2 operand
kill_i  in  1  abort current operation (pipeline flush)
res_valid_o  out  1  result available
res_ready_i  in  1  consumer takes result
res_o  out  XLEN  result
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i high at an edge): state=IDLE, counter=0, res_o=0, res_valid_o=0, req_ready_o=1, busy_o=0. Reset wins over every other input, including mid-operation.
- req_ready_o = (state==IDLE). Request accepted on an edge with req_valid_i && req_ready_o && !kill_i. op_i, a_i and b_i are captured at that edge and then ignored.
- States: IDLE, CALC, FIX, DONE.
  - IDLE -> CALC on accept (normal case).
  - IDLE -> DONE on accept for the special divide cases below.
  - CALC -> FIX when counter == XLEN-1.
  - FIX -> DONE.
  - DONE -> IDLE when res_ready_i.
- Latency: res_valid_o rises XLEN+1 edges after the accepting edge (33 for XLEN=32). One idle bubble follows between back-to-back operations.
- Signedness: operands are converted to magnitudes at accept.
  - a is signed for MULH, MULHSU, DIV, REM.
  - b is signed for MULH, DIV, REM.
  - Product sign = sa^sb. Quotient sign = sa^sb. Remainder sign = sa.
- MUL path: 2*XLEN accumulator; add the shifted multiplicand when the multiplier LSB is 1; one bit per CALC cycle. FIX negates the product if its sign is set, then selects:
  - low XLEN bits for MUL;
  - high XLEN bits for MULH, MULHSU, MULHU.
- DIV path: restoring, one quotient bit per CALC cycle (remainder shift-in MSB first, trial subtract). FIX applies sign correction and selects quotient (DIV/DIVU) or remainder (REM/REMU).
- Special cases, resolved at accept and going straight to DONE (res_valid_o one edge after accept):
  - b==0: DIV/DIVU -> all ones; REM/REMU -> a.
  - DIV with a==1<<(XLEN-1) and b==all ones -> a; REM with the same operands -> 0.
- DONE: res_o and res_valid_o held stable until res_ready_i. Both are registered outputs.
- kill_i high at an edge in CALC, FIX or DONE: next state IDLE, res_valid_o=0, result discarded. kill_i in IDLE blocks acceptance that cycle.

Optional Feature:
RV_MDU_FAST_MUL_EN:
- Defined: MUL/MULH/MULHSU/MULHU bypass CALC. IDLE -> FIX on accept, and FIX registers a full single-cycle XLEN x XLEN product with signedness applied. res_valid_o rises 2 edges after accept.
- Undefined: multiply uses the iterative path described above.
- Divide behaviour is identical in both builds.

Decomposition:
- rv_mdu_pkg gains:
  - typedef enum logic [1:0] mdu_state_e {MDU_IDLE, MDU_CALC, MDU_FIX, MDU_DONE};
  - helper functions is_div(op), a_signed(op), b_signed(op).
  - MDU_OP_W and the op codes stay as they are.
- One natural sub-module: rv_mdu_divstep, a combinational single restoring step: in remainder, dividend MSB, divisor; out next remainder, quotient bit. All other logic stays in rv_mdu_iter.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> 0xFFFFFFEB. MULH 0x80000000 x 0x80000000 -> 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. Each res_valid_o exactly 33 edges after accept (2 with RV_MDU_FAST_MUL_EN).
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14; REMU 100/7 -> 2. Latency 33.
- DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0. All valid 1 edge after accept.
- Backpressure: res_ready_i held low 5 cycles in DONE -> res_o and res_valid_o stable, req_ready_o=0, new req_valid_i not accepted; on release, IDLE next edge.
- kill_i asserted 10 edges into a DIVU -> IDLE next edge, no res_valid_o pulse, and the following request MUL 3 x 4 returns 12.
- rst_i asserted mid-CALC -> all outputs at reset values next edge; the in-flight result is never presented.
